// File: rtl/xnor_match_seq_if.sv
// Start/busy/done handshake and operand/result bus for xnor_match_seq.
// master drives the request side, slave is the comparator.
interface xnor_match_seq_if #(
   parameter int WIDTH = 8
);
   logic                         start;
   logic [WIDTH-1:0]             a;
   logic [WIDTH-1:0]             b;
   logic                         busy;
   logic                         done;
   logic [$clog2(WIDTH+1)-1:0]   match_cnt;
   logic                         equal;

   modport master (
      output start,
      output a,
      output b,
      input  busy,
      input  done,
      input  match_cnt,
      input  equal
   );

   modport slave (
      input  start,
      input  a,
      input  b,
      output busy,
      output done,
      output match_cnt,
      output equal
   );
endinterface

// File: rtl/xnor_match_seq.sv
// Bit-serial comparator: one shared XNOR cell evaluates one bit pair
// per clock, LSB first, and accumulates the number of matching bits.
module xnor_cell (
   input  logic x,
   input  logic y,
   output logic z
);
   assign z = ~(x ^ y);
endmodule

module xnor_match_seq #(
   parameter int WIDTH = 8
) (
   input logic             clk,
   input logic             rst,
   xnor_match_seq_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);
   // bit index needs at least one bit even when WIDTH is 1
   localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);
   localparam logic [CW-1:0] FULL = CW'(WIDTH);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t state_q;
   state_t state_d;

   logic [WIDTH-1:0] sa_q;
   logic [WIDTH-1:0] sb_q;
   logic [BW-1:0]    bit_q;
   logic [CW-1:0]    cnt_q;
   logic             eq_q;

   logic             bit_match;
   logic [CW-1:0]    cnt_inc;
   logic             accept;
   logic             last_bit;

   xnor_cell u_xnor (
      .x (sa_q[0]),
      .y (sb_q[0]),
      .z (bit_match)
   );

   assign cnt_inc  = cnt_q + CW'(bit_match);
   assign accept   = (state_q == IDLE) && bus.start;
   assign last_bit = (state_q == SHIFT) && (bit_q == LAST);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (bus.start) state_d = SHIFT;
         end
         SHIFT: begin
            if (bit_q == LAST) state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // operands are frozen at accept; results hold until the next accept
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sa_q  <= '0;
         sb_q  <= '0;
         bit_q <= '0;
         cnt_q <= '0;
         eq_q  <= 1'b0;
      end else if (accept) begin
         sa_q  <= bus.a;
         sb_q  <= bus.b;
         bit_q <= '0;
         cnt_q <= '0;
         eq_q  <= 1'b0;
      end else if (state_q == SHIFT) begin
         sa_q  <= sa_q >> 1;
         sb_q  <= sb_q >> 1;
         bit_q <= bit_q + BW'(1);
         cnt_q <= cnt_inc;
         if (last_bit) eq_q <= (cnt_inc == FULL);
      end
   end

   assign bus.busy      = (state_q == SHIFT);
   assign bus.done      = (state_q == DONE);
   assign bus.match_cnt = cnt_q;
   assign bus.equal     = eq_q;
endmodule

// File: tb/tb_xnor_match_seq.sv
// Directed bench for xnor_match_seq: WIDTH=8 and WIDTH=1 instances.
module tb_xnor_match_seq;
   logic clk = 1'b0;
   logic rst = 1'b1;

   int checks = 0;
   int passes = 0;

   xnor_match_seq_if #(.WIDTH(8)) bus8 ();
   xnor_match_seq_if #(.WIDTH(1)) bus1 ();

   xnor_match_seq #(.WIDTH(8)) dut8 (
      .clk (clk),
      .rst (rst),
      .bus (bus8.slave)
   );

   xnor_match_seq #(.WIDTH(1)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1.slave)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus8.start = 1'b0; bus8.a = '0; bus8.b = '0;
      bus1.start = 1'b0; bus1.a = '0; bus1.b = '0;
      tick(); tick();
      checks++;
      if ({bus8.busy, bus8.done, bus8.match_cnt, bus8.equal} !== 7'd0)
         $display("FAIL reset8: got %b expected 0",
                  {bus8.busy, bus8.done, bus8.match_cnt, bus8.equal});
      else passes++;
      checks++;
      if ({bus1.busy, bus1.done, bus1.match_cnt, bus1.equal} !== 4'd0)
         $display("FAIL reset1: got %b expected 0",
                  {bus1.busy, bus1.done, bus1.match_cnt, bus1.equal});
      else passes++;
      rst = 1'b0;
      tick();
   endtask

   task automatic test_equal();
      int nb;
      bus8.a = 8'hA5; bus8.b = 8'hA5; bus8.start = 1'b1;
      tick();
      bus8.start = 1'b0;
      checks++;
      if (bus8.match_cnt !== 4'd0)
         $display("FAIL eq_cnt_start: got %0d expected 0", bus8.match_cnt);
      else passes++;
      nb = 0;
      for (int i = 0; i < 8; i++) begin
         if (bus8.busy === 1'b1 && bus8.done === 1'b0) nb++;
         tick();
      end
      checks++;
      if (nb != 8) $display("FAIL eq_busy: got %0d expected 8", nb);
      else passes++;
      checks++;
      if (bus8.done !== 1'b1 || bus8.busy !== 1'b0)
         $display("FAIL eq_done: got d%b b%b expected d1 b0",
                  bus8.done, bus8.busy);
      else passes++;
      checks++;
      if (bus8.match_cnt !== 4'd8 || bus8.equal !== 1'b1)
         $display("FAIL eq_result: got %0d/%b expected 8/1",
                  bus8.match_cnt, bus8.equal);
      else passes++;
      tick();
      checks++;
      if (bus8.done !== 1'b0 || bus8.match_cnt !== 4'd8)
         $display("FAIL eq_after: got d%b cnt%0d expected d0 cnt8",
                  bus8.done, bus8.match_cnt);
      else passes++;
   endtask

   task automatic test_all_diff();
      int nb;
      bus8.a = 8'h00; bus8.b = 8'hFF; bus8.start = 1'b1;
      tick();
      bus8.start = 1'b0;
      checks++;
      if (bus8.equal !== 1'b0 || bus8.match_cnt !== 4'd0)
         $display("FAIL diff_clear: got %0d/%b expected 0/0",
                  bus8.match_cnt, bus8.equal);
      else passes++;
      nb = 0;
      for (int i = 0; i < 8; i++) begin
         if (bus8.busy === 1'b1) nb++;
         tick();
      end
      checks++;
      if (nb != 8 || bus8.done !== 1'b1)
         $display("FAIL diff_timing: got busy%0d d%b expected busy8 d1",
                  nb, bus8.done);
      else passes++;
      checks++;
      if (bus8.match_cnt !== 4'd0 || bus8.equal !== 1'b0)
         $display("FAIL diff_result: got %0d/%b expected 0/0",
                  bus8.match_cnt, bus8.equal);
      else passes++;
      tick();
   endtask

   task automatic test_operand_change();
      int nb;
      bus8.a = 8'hF0; bus8.b = 8'hFF; bus8.start = 1'b1;
      tick();
      bus8.a = 8'hFF;
      nb = 0;
      for (int i = 0; i < 8; i++) begin
         if (bus8.busy === 1'b1) nb++;
         tick();
      end
      checks++;
      if (nb != 8 || bus8.done !== 1'b1)
         $display("FAIL chg_timing: got busy%0d d%b expected busy8 d1",
                  nb, bus8.done);
      else passes++;
      checks++;
      if (bus8.match_cnt !== 4'd4 || bus8.equal !== 1'b0)
         $display("FAIL chg_result: got %0d/%b expected 4/0",
                  bus8.match_cnt, bus8.equal);
      else passes++;
      tick();
      checks++;
      if (bus8.busy !== 1'b0 || bus8.done !== 1'b0)
         $display("FAIL chg_idle: got b%b d%b expected b0 d0",
                  bus8.busy, bus8.done);
      else passes++;
      tick();
      bus8.start = 1'b0;
      checks++;
      if (bus8.busy !== 1'b1 || bus8.match_cnt !== 4'd0)
         $display("FAIL chg_reaccept: got b%b cnt%0d expected b1 cnt0",
                  bus8.busy, bus8.match_cnt);
      else passes++;
      for (int i = 0; i < 8; i++) tick();
      checks++;
      if (bus8.done !== 1'b1 || bus8.match_cnt !== 4'd8
          || bus8.equal !== 1'b1)
         $display("FAIL chg_second: got d%b %0d/%b expected d1 8/1",
                  bus8.done, bus8.match_cnt, bus8.equal);
      else passes++;
      tick();
   endtask

   task automatic test_mid_reset();
      int nd;
      bus8.a = 8'hFF; bus8.b = 8'hFF; bus8.start = 1'b1;
      tick();
      bus8.start = 1'b0;
      tick(); tick();
      checks++;
      if (bus8.match_cnt !== 4'd2)
         $display("FAIL rst_partial: got %0d expected 2", bus8.match_cnt);
      else passes++;
      rst = 1'b1;
      #1;
      checks++;
      if ({bus8.busy, bus8.done, bus8.match_cnt, bus8.equal} !== 7'd0)
         $display("FAIL rst_async: got %b expected 0",
                  {bus8.busy, bus8.done, bus8.match_cnt, bus8.equal});
      else passes++;
      tick();
      rst = 1'b0;
      nd = 0;
      for (int i = 0; i < 10; i++) begin
         if (bus8.done !== 1'b0 || bus8.busy !== 1'b0) nd++;
         tick();
      end
      checks++;
      if (nd != 0) $display("FAIL rst_nodone: got %0d expected 0", nd);
      else passes++;
      bus8.a = 8'h3C; bus8.b = 8'h3D; bus8.start = 1'b1;
      tick();
      bus8.start = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      checks++;
      if (bus8.done !== 1'b1 || bus8.match_cnt !== 4'd7
          || bus8.equal !== 1'b0)
         $display("FAIL rst_fresh: got d%b %0d/%b expected d1 7/0",
                  bus8.done, bus8.match_cnt, bus8.equal);
      else passes++;
      tick();
   endtask

   task automatic test_done_start();
      int nb;
      bus8.a = 8'h5A; bus8.b = 8'h5A; bus8.start = 1'b1;
      tick();
      bus8.start = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      checks++;
      if (bus8.done !== 1'b1)
         $display("FAIL ds_done: got %b expected 1", bus8.done);
      else passes++;
      bus8.a = 8'hC3; bus8.b = 8'hC3; bus8.start = 1'b1;
      tick();
      bus8.start = 1'b0;
      checks++;
      if (bus8.busy !== 1'b0 || bus8.match_cnt !== 4'd8
          || bus8.equal !== 1'b1)
         $display("FAIL ds_ignored: got b%b %0d/%b expected b0 8/1",
                  bus8.busy, bus8.match_cnt, bus8.equal);
      else passes++;
      tick(); tick();
      checks++;
      if (bus8.busy !== 1'b0 || bus8.match_cnt !== 4'd8
          || bus8.equal !== 1'b1)
         $display("FAIL ds_hold: got b%b %0d/%b expected b0 8/1",
                  bus8.busy, bus8.match_cnt, bus8.equal);
      else passes++;
      bus8.start = 1'b1;
      tick();
      bus8.start = 1'b0;
      checks++;
      if (bus8.busy !== 1'b1 || bus8.match_cnt !== 4'd0
          || bus8.equal !== 1'b0)
         $display("FAIL ds_accept: got b%b %0d/%b expected b1 0/0",
                  bus8.busy, bus8.match_cnt, bus8.equal);
      else passes++;
      nb = 0;
      for (int i = 0; i < 8; i++) begin
         if (bus8.busy === 1'b1) nb++;
         tick();
      end
      checks++;
      if (nb != 8 || bus8.done !== 1'b1 || bus8.match_cnt !== 4'd8)
         $display("FAIL ds_second: got busy%0d d%b cnt%0d expected 8 1 8",
                  nb, bus8.done, bus8.match_cnt);
      else passes++;
      tick();
   endtask

   task automatic test_width1();
      logic pa [4];
      logic pb [4];
      logic ec [4];
      pa = '{1'b0, 1'b0, 1'b1, 1'b1};
      pb = '{1'b0, 1'b1, 1'b0, 1'b1};
      ec = '{1'b1, 1'b0, 1'b0, 1'b1};
      for (int k = 0; k < 4; k++) begin
         bus1.a = pa[k]; bus1.b = pb[k]; bus1.start = 1'b1;
         tick();
         bus1.start = 1'b0;
         checks++;
         if (bus1.busy !== 1'b1 || bus1.done !== 1'b0)
            $display("FAIL w1_busy%0d: got b%b d%b expected b1 d0",
                     k, bus1.busy, bus1.done);
         else passes++;
         tick();
         checks++;
         if (bus1.done !== 1'b1 || bus1.match_cnt !== ec[k]
             || bus1.equal !== ec[k])
            $display("FAIL w1_result%0d: got d%b %0d/%b expected d1 %0d/%b",
                     k, bus1.done, bus1.match_cnt, bus1.equal, ec[k], ec[k]);
         else passes++;
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_equal();
      test_all_diff();
      test_operand_change();
      test_mid_reset();
      test_done_start();
      test_width1();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
